// File: rtl/qspi_apb_sequencer.sv
// qspi_apb_sequencer: APB master that runs one direct-mode QSPI frame per request (frame write, busy poll, done poll, optional readback).
// Latency: every APB access is 2 cycles plus slave wait states; rsp_valid follows the last access by one cycle (illegal mode: next cycle).
// Backpressure: req_ready is low from the cycle after a handshake until the cycle after rsp_valid; responses cannot be stalled.
// Ports: PCLK / PRESETn        clock and asynchronous active-low reset
//        req_*                 request handshake plus frame fields (direction, mode, cycle count, payload)
//        rsp_*                 one-cycle response pulse with status and read data
//        PADDR..PWDATA, PRDATA, PREADY   APB master towards the QSPI slave
module qspi_apb_sequencer #(
  parameter logic [31:0] CFG_INIT = 32'h0000_0000,
  parameter logic [7:0]  POLL_MAX = 8'd255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_mode,
  input  logic [3:0]  req_cycles,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [15:0] rsp_rdata,
  output logic [4:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [2:0] {
    CFG, IDLE, WFRAME, POLL_BUSY, POLL_DONE, RDATA, RESP
  } state_t;

  localparam logic [4:0] ADDR_CFG   = 5'h00;
  localparam logic [4:0] ADDR_FRAME = 5'h04;
  localparam logic [4:0] ADDR_STAT  = 5'h08;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BUSY_TO  = 2'b01;
  localparam logic [1:0] ST_DONE_TO  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL  = 2'b11;

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_status_q;
  logic [15:0] rsp_rdata_q;
  logic [4:0]  paddr_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [31:0] pwdata_q;
  logic        write_q;
  logic [7:0]  poll_cnt_q;

  logic [31:0] frame_d;
  logic        access_done_d;
  logic        poll_last_d;
  logic        unused_prdata;

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign PADDR      = paddr_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;

  // Upper half of the status/data word carries nothing this block needs.
  assign unused_prdata = ^PRDATA[31:16];

  always_comb begin
    // Bit 31 is the engine's read flag; reads clock out all-ones on the data lines.
    frame_d       = {~req_write, 1'b0, req_mode, 8'h00, req_cycles,
                     req_write ? req_wdata : 16'hFFFF};
    access_done_d = psel_q & penable_q & PREADY;
    // poll_cnt_q counts completed polls before the current one.
    poll_last_d   = (poll_cnt_q == POLL_MAX - 8'd1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= CFG;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= 16'h0000;
      paddr_q      <= 5'h00;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= 32'h0;
      write_q      <= 1'b0;
      poll_cnt_q   <= 8'h00;
    end else begin
      case (state_q)
        CFG: begin
          if (!psel_q) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= ADDR_CFG;
            pwrite_q  <= 1'b1;
            pwdata_q  <= CFG_INIT;
          end else if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (access_done_d) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= 5'h00;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            if (req_mode == 2'b11) begin
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_ILLEGAL;
              rsp_rdata_q  <= 16'h0000;
              state_q      <= RESP;
            end else begin
              // Frame write SETUP is issued directly from the handshake cycle.
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              paddr_q   <= ADDR_FRAME;
              pwrite_q  <= 1'b1;
              pwdata_q  <= frame_d;
              state_q   <= WFRAME;
            end
          end
        end

        WFRAME: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (access_done_d) begin
            penable_q  <= 1'b0;
            paddr_q    <= ADDR_STAT;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 32'h0;
            poll_cnt_q <= 8'h00;
            state_q    <= POLL_BUSY;
          end
        end

        POLL_BUSY: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (access_done_d) begin
            // Ending ACCESS with PSEL still high makes the next cycle a SETUP.
            penable_q <= 1'b0;
            if (!PRDATA[1]) begin
              poll_cnt_q <= 8'h00;
              state_q    <= POLL_DONE;
            end else if (poll_last_d) begin
              psel_q       <= 1'b0;
              paddr_q      <= 5'h00;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_BUSY_TO;
              rsp_rdata_q  <= 16'h0000;
              state_q      <= RESP;
            end else begin
              poll_cnt_q <= poll_cnt_q + 8'd1;
            end
          end
        end

        POLL_DONE: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (access_done_d) begin
            penable_q <= 1'b0;
            if (PRDATA[1]) begin
              if (write_q) begin
                psel_q       <= 1'b0;
                paddr_q      <= 5'h00;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_OK;
                rsp_rdata_q  <= 16'h0000;
                state_q      <= RESP;
              end else begin
                paddr_q <= ADDR_FRAME;
                state_q <= RDATA;
              end
            end else if (poll_last_d) begin
              psel_q       <= 1'b0;
              paddr_q      <= 5'h00;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_DONE_TO;
              rsp_rdata_q  <= 16'h0000;
              state_q      <= RESP;
            end else begin
              poll_cnt_q <= poll_cnt_q + 8'd1;
            end
          end
        end

        RDATA: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (access_done_d) begin
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= 5'h00;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_OK;
            rsp_rdata_q  <= PRDATA[15:0];
            state_q      <= RESP;
          end
        end

        RESP: begin
          // Response fields are only meaningful alongside the pulse.
          rsp_valid_q  <= 1'b0;
          rsp_status_q <= 2'b00;
          rsp_rdata_q  <= 16'h0000;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= CFG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_apb_sequencer.sv
module tb_qspi_apb_sequencer;

  localparam logic [31:0] CFG_INIT = 32'hC0DE_0042;
  localparam int          PM       = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_mode;
  logic [3:0]  req_cycles;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_rdata;
  logic [4:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  qspi_apb_sequencer #(.CFG_INIT(CFG_INIT), .POLL_MAX(8'(PM))) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_cycles(req_cycles), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct {
    bit        wr;
    bit [1:0]  mode;
    bit [3:0]  cyc;
    bit [15:0] wd;
    int        nb;       // status reads with bit1=1 before the busy edge
    int        nd;       // status reads with bit1=0 before the ready edge
    int        ws;       // wait states per access
    bit [31:0] rd;       // word returned by the 0x04 readback
    bit [31:0] e_frame;
    bit [1:0]  e_st;
    bit [15:0] e_rdata;
    int        e_polls;
    int        e_nacc;
    int        e_lat;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wd;
  } acc_t;

  int   n_err = 0;
  int   n_checks = 0;
  int   cyc = 0;
  int   ws = 0;
  int   psel_cycles = 0;
  int   rsp_cnt = 0;
  logic [31:0] rd_val = 32'h0;
  bit   stat_q[$];
  acc_t log_q[$];

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  // Behavioural APB slave plus bus monitor, updated on the falling edge.
  initial begin
    logic [4:0]  cap_addr;
    logic        cap_wr;
    logic [31:0] cap_wd;
    logic [31:0] s;
    int          wait_left;
    bit          stable;
    cap_addr = '0; cap_wr = 1'b0; cap_wd = '0; wait_left = 0; stable = 1'b1;
    PREADY = 1'b0;
    PRDATA = 32'h0;
    forever begin
      @(negedge PCLK);
      if (PSEL) psel_cycles++;
      if (rsp_valid) rsp_cnt++;
      if (PENABLE) check("penable_needs_psel", 64'(PSEL), 64'd1);
      PRDATA = $urandom;
      if (PSEL && !PENABLE) begin
        cap_addr = PADDR; cap_wr = PWRITE; cap_wd = PWDATA;
        wait_left = ws;
        stable = 1'b1;
        PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        if ({PADDR, PWRITE, PWDATA} !== {cap_addr, cap_wr, cap_wd}) stable = 1'b0;
        if (wait_left == 0) begin
          PREADY = 1'b1;
          if (!PWRITE && PADDR == 5'h08) begin
            s = $urandom;
            if (stat_q.size() > 0) s[1] = stat_q.pop_front();
            else s[1] = 1'b1;
            PRDATA = s;
          end else if (!PWRITE && PADDR == 5'h04) begin
            PRDATA = rd_val;
          end
          log_q.push_back('{PADDR, PWRITE, PWDATA});
          check("apb_hold_stable", 64'(stable), 64'd1);
        end else begin
          PREADY = 1'b0;
          wait_left--;
        end
      end else begin
        PREADY = 1'b0;
      end
    end
  end

  // Reference: sequence length and outcome follow from how many polls each phase needs.
  function automatic vec_t ref_model(bit wr, bit [1:0] mode, bit [3:0] c, bit [15:0] wd,
                                     int nb, int nd, int w, bit [31:0] rd);
    vec_t v;
    v.wr = wr; v.mode = mode; v.cyc = c; v.wd = wd;
    v.nb = nb; v.nd = nd; v.ws = w; v.rd = rd;
    v.e_frame = {~wr, 1'b0, mode, 8'h00, c, (wr ? wd : 16'hFFFF)};
    v.e_rdata = 16'h0;
    if (mode == 2'b11) begin
      v.e_st = 2'b11; v.e_polls = 0; v.e_nacc = 0; v.e_lat = 1;
    end else begin
      if (nb >= PM) begin
        v.e_st = 2'b01; v.e_polls = PM;
      end else if (nd >= PM) begin
        v.e_st = 2'b10; v.e_polls = nb + 1 + PM;
      end else begin
        v.e_st = 2'b00; v.e_polls = nb + 1 + nd + 1;
        if (!wr) v.e_rdata = rd[15:0];
      end
      v.e_nacc = 1 + v.e_polls + ((v.e_st == 2'b00 && !wr) ? 1 : 0);
      v.e_lat  = 1 + v.e_nacc * (2 + w);
    end
    return v;
  endfunction

  task automatic run_req(input vec_t v, input string tag);
    int t0;
    int lat;
    int polls;
    int rds;
    int exp_rds;
    ws = v.ws;
    rd_val = v.rd;
    stat_q.delete();
    repeat (v.nb) stat_q.push_back(1'b1);
    stat_q.push_back(1'b0);
    repeat (v.nd) stat_q.push_back(1'b0);
    stat_q.push_back(1'b1);
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    check({tag, "_ready_before"}, 64'(req_ready), 64'd1);
    log_q.delete();
    psel_cycles = 0;
    req_valid = 1'b1; req_write = v.wr; req_mode = v.mode;
    req_cycles = v.cyc; req_wdata = v.wd;
    t0 = cyc;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_mode = 2'($urandom);
    req_cycles = 4'($urandom); req_wdata = 16'($urandom);
    check({tag, "_ready_drop"}, 64'(req_ready), 64'd0);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin
        lat = cyc - t0;
        break;
      end
      tick();
    end
    if (lat < 0) begin
      check({tag, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(lat), 64'(v.e_lat));
      check({tag, "_status"}, 64'(rsp_status), 64'(v.e_st));
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.e_rdata));
    end
    polls = 0; rds = 0;
    foreach (log_q[i]) begin
      if (log_q[i].addr == 5'h08 && !log_q[i].wr) polls++;
      if (log_q[i].addr == 5'h04 && !log_q[i].wr) rds++;
    end
    exp_rds = (v.e_st == 2'b00 && !v.wr) ? 1 : 0;
    check({tag, "_accesses"}, 64'(log_q.size()), 64'(v.e_nacc));
    check({tag, "_status_polls"}, 64'(polls), 64'(v.e_polls));
    check({tag, "_readbacks"}, 64'(rds), 64'(exp_rds));
    check({tag, "_psel_cycles"}, 64'(psel_cycles), 64'(v.e_nacc * (2 + v.ws)));
    if (v.e_nacc > 0 && log_q.size() > 0)
      check({tag, "_frame_write"}, 64'(log_q[0]), 64'({5'h04, 1'b1, v.e_frame}));
    tick();
    check({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 2'd0, 4'hF, 16'h0000, 1, 1, 0, 32'h0000_A5C3, 32'h800F_FFFF, 2'b00, 16'hA5C3, 4, 6, 13};
    tbl[1] = '{1'b1, 2'd2, 4'h3, 16'h1234, 0, 0, 0, 32'hDEAD_0000, 32'h2003_1234, 2'b00, 16'h0000, 2, 3, 7};
    tbl[2] = '{1'b0, 2'd0, 4'h0, 16'h7777, 0, 0, 0, 32'hFFFF_0042, 32'h8000_FFFF, 2'b00, 16'h0042, 2, 4, 9};
    tbl[3] = '{1'b1, 2'd1, 4'h7, 16'hBEEF, 9, 0, 0, 32'h0000_0000, 32'h1007_BEEF, 2'b01, 16'h0000, 4, 5, 11};
    tbl[4] = '{1'b0, 2'd2, 4'h8, 16'h0000, 0, 9, 0, 32'h0000_1111, 32'hA008_FFFF, 2'b10, 16'h0000, 5, 6, 13};
    tbl[5] = '{1'b1, 2'd1, 4'h1, 16'h0001, 3, 3, 0, 32'h0000_0000, 32'h1001_0001, 2'b00, 16'h0000, 8, 9, 19};
    tbl[6] = '{1'b1, 2'd3, 4'h5, 16'h5555, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 2'b11, 16'h0000, 0, 0, 1};
    tbl[7] = '{1'b0, 2'd0, 4'h2, 16'h0000, 0, 0, 3, 32'h1234_5678, 32'h8002_FFFF, 2'b00, 16'h5678, 2, 4, 21};

    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00;
    req_cycles = 4'h0; req_wdata = 16'h0;

    // Reset state and the boot-time configuration write.
    repeat (3) tick();
    check("reset_outputs",
          64'({req_ready, rsp_valid, rsp_status, rsp_rdata, PADDR, PSEL, PENABLE, PWRITE, PWDATA}),
          64'd0);
    ws = 1;
    log_q.delete();
    PRESETn = 1'b1;
    for (int i = 0; i < 50 && log_q.size() == 0; i++) tick();
    check("boot_access_seen", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) check("boot_cfg_write", 64'(log_q[0]), 64'({5'h00, 1'b1, CFG_INIT}));
    check("boot_ready_low_at_done", 64'(req_ready), 64'd0);
    tick();
    check("boot_ready_rise", 64'(req_ready), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Randomised requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = ref_model(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2), $urandom);
      run_req(v, $sformatf("rand%0d", i));
    end

    // Reset asserted while polling for done, with 3 wait states on every access.
    ws = 3;
    stat_q.delete();
    repeat (30) stat_q.push_back(1'b0);
    rd_val = 32'h0000_9999;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    log_q.delete();
    req_valid = 1'b1; req_write = 1'b0; req_mode = 2'b00; req_cycles = 4'h4; req_wdata = 16'h0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 100 && log_q.size() < 2; i++) tick();
    check("mid_busy_phase_done", 64'(log_q.size()), 64'd2);
    repeat (3) tick();
    check("mid_in_done_poll", 64'({PSEL, PADDR}), 64'({1'b1, 5'h08}));
    PRESETn = 1'b0;
    #1;
    check("mid_reset_bus_idle", 64'({PSEL, PENABLE}), 64'd0);
    tick();
    tick();
    check("mid_reset_outputs",
          64'({req_ready, rsp_valid, rsp_status, rsp_rdata, PADDR, PSEL, PENABLE, PWRITE, PWDATA}),
          64'd0);
    log_q.delete();
    stat_q.delete();
    rsp_cnt = 0;
    PRESETn = 1'b1;
    for (int i = 0; i < 100 && log_q.size() == 0; i++) tick();
    check("restart_access_seen", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) check("restart_cfg_write", 64'(log_q[0]), 64'({5'h00, 1'b1, CFG_INIT}));
    tick();
    check("restart_ready", 64'(req_ready), 64'd1);
    repeat (20) tick();
    check("restart_no_response", 64'(rsp_cnt), 64'd0);
    check("restart_no_extra_access", 64'(log_q.size()), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_apb_sequencer.md
# qspi_apb_sequencer

APB master front-end for `tiny_qspi_apb` that turns a simple request/response handshake into the register sequence for a single direct-mode QSPI frame. The sequence is: write the frame word, poll status until the engine goes busy, poll again until it returns to ready, then read back the result on read frames. It sits directly upstream of the QSPI APB slave, replacing software polling. Its first action after reset is a one-time configuration write.

## Interface
Parameters:
- `CFG_INIT`, 32'h0000_0000: value written to config register 0x00 after reset.
- `POLL_MAX`, 8'd255: maximum status polls per poll phase before timeout.

Ports:
- `PCLK` in 1: clock.
- `PRESETn` in 1: reset. Asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_write` in 1: 1 = write frame, 0 = read frame.
- `req_mode` in 2: 00 SPI, 01 DPI, 10 QPI, 11 illegal.
- `req_cycles` in 4: frame cycle count field.
- `req_wdata` in 16: write payload.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_status` out 2: 00 ok, 01 busy timeout, 10 done timeout, 11 illegal mode.
- `rsp_rdata` out 16: read result. Valid with `rsp_valid` when the request was a read with status ok; otherwise 0.
- `PADDR` out 5, `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out 32: APB master outputs.
- `PRDATA` in 32, `PREADY` in 1: APB slave responses.

## Operation
- FSM states: CFG, IDLE, WFRAME, POLL_BUSY, POLL_DONE, RDATA, RESP.
- CFG: APB write of `CFG_INIT` to 0x00, then go to IDLE. `req_ready` stays 0 until this completes.
- IDLE:
  - `req_ready`=1. On `req_valid` the request fields are latched.
  - mode 11: go to RESP with status 11. No APB traffic.
  - Otherwise go to WFRAME.
- WFRAME: APB write to 0x04. PWDATA bit layout:
  - [31] = ~req_write
  - [30] = 0
  - [29:28] = mode
  - [27:20] = 0
  - [19:16] = cycles
  - [15:0] = wdata for writes, 16'hFFFF for reads
- POLL_BUSY:
  - Repeated APB reads of 0x08.
  - PRDATA[1]==0 (busy): go to POLL_DONE.
  - After `POLL_MAX` polls still reading 1: go to RESP with status 01.
- POLL_DONE:
  - Repeated reads of 0x08.
  - PRDATA[1]==1: go to RDATA for reads, RESP for writes.
  - After `POLL_MAX` polls still busy: go to RESP with status 10.
  - The poll counter is cleared on entry to each poll phase.
- RDATA: APB read of 0x04. Capture PRDATA[15:0] into `rsp_rdata`, then go to RESP.
- RESP: `rsp_valid`=1 for one cycle, then go to IDLE. There is no response backpressure.
- Poll counter is 8 bits. Timeout triggers when a completed poll fails and the count equals `POLL_MAX`. A poll that succeeds on the `POLL_MAX`-th attempt is a success.

## Timing
- Every APB access is SETUP (PSEL=1, PENABLE=0) for 1 cycle, then ACCESS (PSEL=1, PENABLE=1).
- ACCESS holds until PREADY=1. PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle.
- PRDATA is sampled on the ACCESS cycle where PREADY=1.
- Consecutive accesses run back-to-back: the next SETUP follows the completing ACCESS with no idle cycle.
- When not accessing, PSEL=PENABLE=0.
- Reset values:
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_status`, `rsp_rdata`, PADDR, PSEL, PENABLE, PWRITE, PWDATA.
  - FSM state = CFG.
- Reset asserted mid-operation: the APB bus drops to idle immediately (asynchronous), the pending request is discarded with no response, and the sequence restarts at CFG after release.
- Latency with PREADY=1 always, counting from the request handshake cycle (cycle 0):
  - Write frame, busy on first poll, ready on first done poll: frame write in cycles 1-2, polls in 3-4 and 5-6, `rsp_valid` in cycle 7.
  - Read frame: same, plus the RDATA access in cycles 7-8, `rsp_valid` in cycle 9.
  - Illegal mode: `rsp_valid` in cycle 1.
- `req_ready` drops in the cycle after a handshake. It returns to 1 in the cycle after `rsp_valid`.

## Test plan
- Reset then idle slave:
  - Required: the first APB access is a write of `CFG_INIT` to 0x00.
  - Required: `req_ready` rises 1 cycle after that access completes.
- SPI read, mode 00, cycles 4'hF:
  - Required: PWDATA = 32'h800F_FFFF at 0x04.
  - Slave answers status bit1 as 1,0,0,1, then data 32'h0000_A5C3.
  - Required: `rsp_status`=00, `rsp_rdata`=16'hA5C3.
- QPI write, mode 10, cycles 3, wdata 16'h1234:
  - Required: PWDATA = 32'h2003_1234.
  - Required: no 0x04 read after polling, `rsp_valid` with status 00.
- Slave never clears status bit1, `POLL_MAX`=4:
  - Required: exactly 4 reads of 0x08, then `rsp_status`=01.
- Mode 11 request:
  - Required: `rsp_valid` with status 11 one cycle later, no PSEL activity.
- PREADY wait states (3 cycles on each access), plus `PRESETn` pulsed low during POLL_DONE:
  - Required: address and data held stable through every wait state.
  - Required: after reset, no response for the discarded request and the bus restarts with the CFG write.
